// File: rtl/cond_eval_stage.sv
// cond_eval_stage: resolves ARM condition codes against forwarded NZCV with S-instruction hazard tracking.
// Optional macro COND_FLUSH_EN adds a flush input that kills the output and clears pending writers.
module cond_eval_stage #(
  parameter int FLAGS_W = 4,
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               reset,
`ifdef COND_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  input  logic [3:0]         in_cond,
  input  logic               in_sets_flags,
  output logic               in_ready,
  input  logic [FLAGS_W-1:0] cpsr_flags,
  input  logic [FLAGS_W-1:0] wb_set,
  input  logic [FLAGS_W-1:0] wb_flags,
  output logic               out_valid,
  output logic               out_pass,
  output logic               out_sets_flags,
  input  logic               out_ready
);
  logic [FLAGS_W-1:0] eff;
  logic [PEND_W-1:0]  pending, pend_next_base;
  logic [7:0]         base;
  logic               wb_any, hazard, full, accept, pass, kill;
  assign eff = (wb_set & wb_flags) | (~wb_set & cpsr_flags);
  assign wb_any = |wb_set;
  assign pend_next_base = pending - PEND_W'(wb_any && pending != '0);
  assign hazard = (pend_next_base != '0) && in_cond != 4'hE;
  assign full = in_sets_flags && pend_next_base == {PEND_W{1'b1}};
`ifdef COND_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif
  assign in_ready = (!out_valid || out_ready) && !hazard && !full && !kill;
  assign accept = in_valid && in_ready;
  // Codes come in complementary pairs: the even code picks a base term, the odd code inverts it.
  assign base = {1'b1, !eff[2] && (eff[3] == eff[0]), eff[3] == eff[0], eff[1] && !eff[2],
                 eff[0], eff[3], eff[1], eff[2]};
  assign pass = base[in_cond[3:1]] ^ in_cond[0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_pass       <= 1'b0;
      out_sets_flags <= 1'b0;
      pending        <= '0;
    end else begin
      pending   <= kill ? '0 : pend_next_base + PEND_W'(accept && in_sets_flags && pass);
      out_valid <= !kill && (accept || (out_valid && !out_ready));
      if (accept) begin
        out_pass       <= pass;
        out_sets_flags <= in_sets_flags && pass;
      end
    end
  end
endmodule

// File: doc/cond_eval_stage.md
Name: cond_eval_stage

Overview:
- Consumer-side counterpart of the CPSR flag register: reads NZCV and resolves each instruction's 4-bit ARM condition field to a registered pass/fail.
- Sits between decode and execute.
- Tracks in-flight flag-setting instructions and stalls condition-dependent instructions until their flags are written.
- Same-cycle CPSR writes are forwarded.

Parameters:
- FLAGS_W, 4, number of condition flags. Index 0=V, 1=C, 2=Z, 3=N, matching CPSR bits 28..31.
- PEND_W, 2, width of the pending-flag-writer counter. Maximum outstanding writers is 2^PEND_W-1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_cond  input  4  ARM condition field
- in_sets_flags  input  1  instruction has S bit and will write CPSR later
- in_ready  output  1  stage accepts instruction this cycle
- cpsr_flags  input  FLAGS_W  current CPSR flags (CPSR out[31:28])
- wb_set  input  FLAGS_W  per-flag CPSR write enables this cycle (same signal driving the CPSR should_set input)
- wb_flags  input  FLAGS_W  CPSR write data this cycle
- out_valid  output  1  result valid
- out_pass  output  1  condition passed
- out_sets_flags  output  1  registered in_sets_flags AND out_pass
- out_ready  input  1  downstream accepts result

Behaviour:
- Reset: asynchronous, active-high. Values while reset is high: out_valid=0, out_pass=0, out_sets_flags=0, pending=0. in_ready is combinational and follows the equation below.
- Effective flags, per bit i: eff[i] = wb_set[i] ? wb_flags[i] : cpsr_flags[i].
- wb_any = OR of wb_set.
- pend_next_base = pending - (wb_any && pending!=0). The counter saturates at 0 and never underflows.
- Hazard: hazard = (pend_next_base != 0) && in_cond != 4'hE.
  - AL does not wait.
  - NV also waits. It is a decided simplification.
- Full stall: full = in_sets_flags && pend_next_base == 2^PEND_W-1.
- in_ready = (!out_valid || out_ready) && !hazard && !full.
- Accept: a transfer occurs when in_valid && in_ready. At the next edge:
  - out_valid=1.
  - out_pass=eval(in_cond, eff).
  - out_sets_flags = in_sets_flags && pass.
- Pending counter at each edge: pending <= pend_next_base + (accept && in_sets_flags && pass).
  - Increment and decrement in the same cycle leave the counter unchanged.
  - A failed S instruction never increments.
- Condition evaluation table:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Output handshake:
  - out_valid && out_ready with no new accept: out_valid <= 0 at the next edge.
  - Output stalled (out_valid && !out_ready): out_pass and out_sets_flags hold stable.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 per cycle when there is no hazard and out_ready=1.
- wb_any with pending==0 (e.g. MSR from elsewhere): flags are still forwarded; the counter stays 0.
- Reset asserted mid-operation: outputs and the counter clear immediately; any in-flight result is discarded.

Optional Feature:
- Macro: COND_FLUSH_EN.
- With the macro defined, an input port flush (1 bit) is added. flush=1 at an edge:
  - out_valid <= 0 and pending <= 0.
  - in_ready is forced to 0 that cycle, and no accept occurs.
  - flush has priority over accept and counter updates.
- Without the macro: no port; behaviour as above.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out_valid=0, out_pass=0, out_sets_flags=0, pending=0 immediately. After release, in_ready=1 with out_valid=0 and pending=0.
- Full table: cpsr_flags=4'b0100 (Z=1), sweep in_cond 0..F with out_ready=1 -> out_pass = 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0, one cycle after each accept.
- Forwarding: cpsr_flags=0, wb_set=4'b0100, wb_flags=4'b0100, in_cond=0 (EQ) -> out_pass=1.
- Hazard stall:
  - Accept an S instruction with cond E -> pending=1.
  - Next cycle, in_cond=1 (NE) with wb_set=0 -> in_ready=0 for each stalled cycle.
  - When wb_set=4'b0100 and wb_flags[Z]=1 -> in_ready=1 and out_pass=0.
  - AL presented during the stall is accepted immediately.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and out_pass holds for 3 cycles. Release -> the next instruction is accepted on the same edge that drains the output.
- Saturation and simultaneity:
  - Three passing S instructions with no wb -> pending=3; a fourth S instruction stalls (full).
  - An S-accept coinciding with wb_any keeps pending unchanged.
  - wb_any at pending=0 keeps pending=0.
